// File: rtl/imem_port_arbiter.sv
// Round-robin arbiter sharing the instruction ROM read port between fetch (port 0) and debug (port 1).
// Optional address range checking is compiled in with `define IMEM_ARB_RANGE_CHECK_EN.
module imem_port_arbiter #(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned MEMORY_DEPTH = 32,
   parameter int unsigned WAIT_STATES  = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req0_i,
   input  logic [DATA_WIDTH-1:0] addr0_i,
   output logic                  gnt0_o,
   output logic                  rvalid0_o,
   output logic [DATA_WIDTH-1:0] rdata0_o,
   output logic                  rerr0_o,
   input  logic                  req1_i,
   input  logic [DATA_WIDTH-1:0] addr1_i,
   output logic                  gnt1_o,
   output logic                  rvalid1_o,
   output logic [DATA_WIDTH-1:0] rdata1_o,
   output logic                  rerr1_o,
   output logic [DATA_WIDTH-1:0] mem_addr_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i,
   output logic                  busy_o
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_WAIT    = 2'd1;
   localparam logic [1:0] ST_CAPTURE = 2'd2;
   localparam logic [3:0] WAIT_INIT  = 4'(WAIT_STATES);

   if (WAIT_STATES > 15) begin : g_bad_wait_states
      $error("WAIT_STATES must be in 0..15");
   end
   if (MEMORY_DEPTH == 0) begin : g_bad_memory_depth
      $error("MEMORY_DEPTH must be non-zero");
   end

   logic [1:0]            state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  last_q, last_d;
   logic                  id_q, id_d;
   logic [DATA_WIDTH-1:0] addr_q, addr_d;
   logic                  bad_q, bad_d;
   logic                  gnt0_q, gnt0_d, gnt1_q, gnt1_d;
   logic                  rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
   logic                  rerr0_q, rerr0_d, rerr1_q, rerr1_d;
   logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
   logic [DATA_WIDTH-1:0] cap_data;
   logic                  win_id;
   logic [DATA_WIDTH-1:0] win_addr;
   logic                  win_bad;

   // On a tie the port that did not win last time gets the grant.
   assign win_id   = (req0_i && req1_i) ? ~last_q : req1_i;
   assign win_addr = win_id ? addr1_i : addr0_i;

`ifdef IMEM_ARB_RANGE_CHECK_EN
   logic [DATA_WIDTH-1:0] word_idx;
   assign word_idx = win_addr >> 2;
   assign win_bad  = (win_addr[1:0] != 2'b00) || (word_idx >= DATA_WIDTH'(MEMORY_DEPTH));
`else
   assign win_bad  = 1'b0;
`endif

   assign cap_data = bad_q ? '0 : mem_rdata_i;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      last_d    = last_q;
      id_d      = id_q;
      addr_d    = addr_q;
      bad_d     = bad_q;
      gnt0_d    = 1'b0;
      gnt1_d    = 1'b0;
      rvalid0_d = 1'b0;
      rvalid1_d = 1'b0;
      rerr0_d   = 1'b0;
      rerr1_d   = 1'b0;
      rdata0_d  = rdata0_q;
      rdata1_d  = rdata1_q;
      case (state_q)
         ST_IDLE: begin
            if (req0_i || req1_i) begin
               id_d   = win_id;
               addr_d = win_addr;
               bad_d  = win_bad;
               last_d = win_id;
               gnt0_d = ~win_id;
               gnt1_d = win_id;
               if (WAIT_STATES > 0) begin
                  state_d = ST_WAIT;
                  cnt_d   = WAIT_INIT;
               end else begin
                  state_d = ST_CAPTURE;
               end
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            if (id_q) begin
               rvalid1_d = 1'b1;
               rdata1_d  = cap_data;
               rerr1_d   = bad_q;
            end else begin
               rvalid0_d = 1'b1;
               rdata0_d  = cap_data;
               rerr0_d   = bad_q;
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 4'd0;
         last_q    <= 1'b1;
         id_q      <= 1'b0;
         addr_q    <= '0;
         bad_q     <= 1'b0;
         gnt0_q    <= 1'b0;
         gnt1_q    <= 1'b0;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         rerr0_q   <= 1'b0;
         rerr1_q   <= 1'b0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         last_q    <= last_d;
         id_q      <= id_d;
         addr_q    <= addr_d;
         bad_q     <= bad_d;
         gnt0_q    <= gnt0_d;
         gnt1_q    <= gnt1_d;
         rvalid0_q <= rvalid0_d;
         rvalid1_q <= rvalid1_d;
         rerr0_q   <= rerr0_d;
         rerr1_q   <= rerr1_d;
         rdata0_q  <= rdata0_d;
         rdata1_q  <= rdata1_d;
      end
   end

   assign gnt0_o     = gnt0_q;
   assign gnt1_o     = gnt1_q;
   assign rvalid0_o  = rvalid0_q;
   assign rvalid1_o  = rvalid1_q;
   assign rdata0_o   = rdata0_q;
   assign rdata1_o   = rdata1_q;
   assign rerr0_o    = rerr0_q;
   assign rerr1_o    = rerr1_q;
   assign busy_o     = (state_q != ST_IDLE);
   // A rejected address is never presented to the ROM.
   assign mem_addr_o = ((state_q != ST_IDLE) && !bad_q) ? addr_q : '0;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench: u_a runs with WAIT_STATES=0, u_b with WAIT_STATES=3; each sees a small ROM model.
module tb_imem_port_arbiter;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

`ifdef IMEM_ARB_RANGE_CHECK_EN
   localparam bit RC = 1'b1;
`else
   localparam bit RC = 1'b0;
`endif

   int checks = 0;
   int failures = 0;

   logic        a_req0 = 1'b0, a_req1 = 1'b0;
   logic [31:0] a_addr0 = '0, a_addr1 = '0;
   logic        a_gnt0, a_gnt1, a_rvalid0, a_rvalid1, a_rerr0, a_rerr1, a_busy;
   logic [31:0] a_rdata0, a_rdata1, a_mem_addr, a_mem_rdata;

   logic        b_req0 = 1'b0, b_req1 = 1'b0;
   logic [31:0] b_addr0 = '0, b_addr1 = '0;
   logic        b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_rerr0, b_rerr1, b_busy;
   logic [31:0] b_rdata0, b_rdata1, b_mem_addr, b_mem_rdata;

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      logic [31:0] idx;
      idx = a >> 2;
      case (idx)
         32'd1:   return 32'h0040_0093;
         32'd3:   return 32'h00A0_0513;
         32'd4:   return 32'h0020_8133;
         default: return (idx < 32'd32) ? (32'hC0DE_0000 | idx) : 32'hDEAD_BEEF;
      endcase
   endfunction

   assign a_mem_rdata = rom_word(a_mem_addr);
   assign b_mem_rdata = rom_word(b_mem_addr);

   imem_port_arbiter #(.DATA_WIDTH(32), .MEMORY_DEPTH(32), .WAIT_STATES(0)) u_a (
      .clk(clk), .reset(reset),
      .req0_i(a_req0), .addr0_i(a_addr0), .gnt0_o(a_gnt0), .rvalid0_o(a_rvalid0),
      .rdata0_o(a_rdata0), .rerr0_o(a_rerr0),
      .req1_i(a_req1), .addr1_i(a_addr1), .gnt1_o(a_gnt1), .rvalid1_o(a_rvalid1),
      .rdata1_o(a_rdata1), .rerr1_o(a_rerr1),
      .mem_addr_o(a_mem_addr), .mem_rdata_i(a_mem_rdata), .busy_o(a_busy)
   );

   imem_port_arbiter #(.DATA_WIDTH(32), .MEMORY_DEPTH(32), .WAIT_STATES(3)) u_b (
      .clk(clk), .reset(reset),
      .req0_i(b_req0), .addr0_i(b_addr0), .gnt0_o(b_gnt0), .rvalid0_o(b_rvalid0),
      .rdata0_o(b_rdata0), .rerr0_o(b_rerr0),
      .req1_i(b_req1), .addr1_i(b_addr1), .gnt1_o(b_gnt1), .rvalid1_o(b_rvalid1),
      .rdata1_o(b_rdata1), .rerr1_o(b_rerr1),
      .mem_addr_o(b_mem_addr), .mem_rdata_i(b_mem_rdata), .busy_o(b_busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state
      #3;
      check("rst_gnt0", 32'(a_gnt0), 32'd0);
      check("rst_gnt1", 32'(a_gnt1), 32'd0);
      check("rst_rvalid0", 32'(a_rvalid0), 32'd0);
      check("rst_rdata0", a_rdata0, 32'd0);
      check("rst_rerr0", 32'(a_rerr0), 32'd0);
      check("rst_mem_addr", a_mem_addr, 32'd0);
      check("rst_busy", 32'(a_busy), 32'd0);
      check("rst_b_busy", 32'(b_busy), 32'd0);
      tick();
      tick();
      reset = 1'b1;

      // Single port-0 read, no wait states
      a_req0 = 1'b1; a_addr0 = 32'h0C;
      tick();
      check("t1_gnt0", 32'(a_gnt0), 32'd1);
      check("t1_gnt1", 32'(a_gnt1), 32'd0);
      check("t1_mem_addr", a_mem_addr, 32'h0C);
      check("t1_busy", 32'(a_busy), 32'd1);
      check("t1_rvalid_early", 32'(a_rvalid0), 32'd0);
      a_req0 = 1'b0;
      tick();
      check("t1_rvalid0", 32'(a_rvalid0), 32'd1);
      check("t1_rdata0", a_rdata0, 32'h00A0_0513);
      check("t1_rerr0", 32'(a_rerr0), 32'd0);
      check("t1_gnt0_drop", 32'(a_gnt0), 32'd0);
      tick();
      check("t1_rvalid0_drop", 32'(a_rvalid0), 32'd0);
      check("t1_rdata0_hold", a_rdata0, 32'h00A0_0513);
      check("t1_idle_busy", 32'(a_busy), 32'd0);
      check("t1_idle_addr", a_mem_addr, 32'd0);

      // Reset pulse restores last_grant so port 0 wins the first tie
      reset = 1'b0;
      #1;
      check("rst2_rdata0", a_rdata0, 32'd0);
      #1;
      reset = 1'b1;

      // Both ports requesting continuously: 0,1,0,1
      a_req0 = 1'b1; a_addr0 = 32'h0C;
      a_req1 = 1'b1; a_addr1 = 32'h10;
      for (int k = 1; k <= 8; k++) begin
         tick();
         check($sformatf("alt%0d_gnt0", k), 32'(a_gnt0), 32'(k % 4 == 1));
         check($sformatf("alt%0d_gnt1", k), 32'(a_gnt1), 32'(k % 4 == 3));
         check($sformatf("alt%0d_rv0", k), 32'(a_rvalid0), 32'(k % 4 == 2));
         check($sformatf("alt%0d_rv1", k), 32'(a_rvalid1), 32'(k % 4 == 0));
         check($sformatf("alt%0d_both", k), 32'(a_gnt0 & a_gnt1), 32'd0);
         if (k == 8) begin
            a_req0 = 1'b0;
            a_req1 = 1'b0;
         end
      end
      tick();
      check("alt_rdata1", a_rdata1, 32'h0020_8133);
      check("alt_rdata0", a_rdata0, 32'h00A0_0513);
      check("alt_busy_end", 32'(a_busy), 32'd0);

      // Port 1 read with three wait states
      b_req1 = 1'b1; b_addr1 = 32'h04;
      tick();
      check("ws_gnt1", 32'(b_gnt1), 32'd1);
      check("ws_mem_addr_c1", b_mem_addr, 32'h04);
      check("ws_busy", 32'(b_busy), 32'd1);
      b_req1 = 1'b0;
      for (int c = 2; c <= 4; c++) begin
         tick();
         check($sformatf("ws_mem_addr_c%0d", c), b_mem_addr, 32'h04);
         check($sformatf("ws_rv1_c%0d", c), 32'(b_rvalid1), 32'd0);
         check($sformatf("ws_busy_c%0d", c), 32'(b_busy), 32'd1);
      end
      tick();
      check("ws_rvalid1", 32'(b_rvalid1), 32'd1);
      check("ws_rdata1", b_rdata1, 32'h0040_0093);
      check("ws_mem_addr_idle", b_mem_addr, 32'd0);
      tick();
      check("ws_rvalid1_drop", 32'(b_rvalid1), 32'd0);

      // Reset in the middle of a waited transaction
      b_req0 = 1'b1; b_addr0 = 32'h08;
      tick();
      check("rw_gnt0", 32'(b_gnt0), 32'd1);
      b_req0 = 1'b0;
      tick();
      reset = 1'b0;
      #1;
      check("rw_busy", 32'(b_busy), 32'd0);
      check("rw_mem_addr", b_mem_addr, 32'd0);
      check("rw_gnt0", 32'(b_gnt0), 32'd0);
      check("rw_rvalid0", 32'(b_rvalid0), 32'd0);
      check("rw_rdata1", b_rdata1, 32'd0);
      #1;
      reset = 1'b1;
      for (int c = 0; c < 6; c++) begin
         tick();
         check($sformatf("rw_no_rv0_%0d", c), 32'(b_rvalid0), 32'd0);
         check($sformatf("rw_idle_%0d", c), 32'(b_busy), 32'd0);
      end
      b_req0 = 1'b1; b_addr0 = 32'h0C;
      b_req1 = 1'b1; b_addr1 = 32'h10;
      tick();
      check("rw_tie_gnt0", 32'(b_gnt0), 32'd1);
      check("rw_tie_gnt1", 32'(b_gnt1), 32'd0);
      b_req0 = 1'b0;
      b_req1 = 1'b0;
      for (int c = 2; c <= 5; c++) tick();
      check("rw_tie_rvalid0", 32'(b_rvalid0), 32'd1);
      check("rw_tie_rdata0", b_rdata0, 32'h00A0_0513);

      // Out-of-range and misaligned addresses
      a_req0 = 1'b1; a_addr0 = 32'h80;
      tick();
      check("oor_gnt0", 32'(a_gnt0), 32'd1);
      check("oor_mem_addr", a_mem_addr, RC ? 32'd0 : 32'h80);
      a_req0 = 1'b0;
      tick();
      check("oor_rvalid0", 32'(a_rvalid0), 32'd1);
      check("oor_rdata0", a_rdata0, RC ? 32'd0 : 32'hDEAD_BEEF);
      check("oor_rerr0", 32'(a_rerr0), RC ? 32'd1 : 32'd0);
      tick();
      check("oor_rerr0_drop", 32'(a_rerr0), 32'd0);
      check("oor_rvalid0_drop", 32'(a_rvalid0), 32'd0);
      a_req0 = 1'b1; a_addr0 = 32'h06;
      tick();
      check("mis_gnt0", 32'(a_gnt0), 32'd1);
      check("mis_mem_addr", a_mem_addr, RC ? 32'd0 : 32'h06);
      a_req0 = 1'b0;
      tick();
      check("mis_rvalid0", 32'(a_rvalid0), 32'd1);
      check("mis_rdata0", a_rdata0, RC ? 32'd0 : 32'h0040_0093);
      check("mis_rerr0", 32'(a_rerr0), RC ? 32'd1 : 32'd0);
      tick();
      check("mis_rerr0_drop", 32'(a_rerr0), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
